serial_subtractor: RTL and testbench

//  Bit-serial WIDTH-bit subtractor computing a_in - b_in, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/serial_subtractor_full_subractor.sv | 13 +
 rtl/serial_subtractor.sv | 92 +++++++++
 tb/tb_serial_subtractor.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encodings and the widest supported operand.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int MAX_SERIAL_WIDTH = 32;

endpackage

// File: rtl/serial_subtractor_full_subractor.sv
// Existing 1-bit full subtractor cell: diff = a - b - c, borrow out when that underflows.
module full_subractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic diff,
    output logic borrow
);

    assign diff   = a ^ b ^ c;
    assign borrow = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full_subractor cell with its borrow looped back through a flop.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > MAX_SERIAL_WIDTH) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of range");
    end

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] d_sh;
    logic [CNT_W-1:0] cnt;
    logic             borrow_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             cell_diff;
    logic             cell_borrow;
    logic [WIDTH-1:0] shift_word;

    full_subractor u_fs (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .c      (borrow_q),
        .diff   (cell_diff),
        .borrow (cell_borrow)
    );

    // Only the newest WIDTH-1 result bits are kept; the oldest falls off as the new one enters.
    assign shift_word = {cell_diff, d_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            d_sh         <= '0;
            cnt          <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh     <= a_in;
                        b_sh     <= b_in;
                        borrow_q <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sh     <= a_sh >> 1;
                    b_sh     <= b_sh >> 1;
                    d_sh     <= shift_word[WIDTH-1:1];
                    borrow_q <= cell_borrow;
                    cnt      <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        diff_q       <= shift_word;
                        borrow_out_q <= cell_borrow;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state == ST_SHIFT);
    assign done       = (state == ST_DONE);
    assign diff_out   = diff_q;
    assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8, plus a short seeded random sweep.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff_out;
    logic         borrow_out;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] prev_d = '0;
    logic         prev_b = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .diff_out   (diff_out),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full operation: start pulsed for one edge, busy counted over W cycles, done checked for one cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_d, input logic exp_b, input string tag);
        int busy_cnt;
        int done_seen;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        busy_cnt  = 0;
        done_seen = 0;
        for (int i = 0; i < W; i++) begin
            if (busy) busy_cnt++;
            if (done) done_seen++;
            if (i == W / 2) begin
                check({tag, "_hold_diff"}, 32'(diff_out), 32'(prev_d));
                check({tag, "_hold_borrow"}, 32'(borrow_out), 32'(prev_b));
            end
            @(negedge clk);
        end
        check({tag, "_busy_len"}, busy_cnt, W);
        check({tag, "_early_done"}, done_seen, 0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_diff"}, 32'(diff_out), 32'(exp_d));
        check({tag, "_borrow"}, 32'(borrow_out), 32'(exp_b));
        @(negedge clk);
        check({tag, "_done_fall"}, 32'(done), 32'd0);
        check({tag, "_diff_keep"}, 32'(diff_out), 32'(exp_d));
        prev_d = exp_d;
        prev_b = exp_b;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(diff_out), 32'd0);
        check("reset_borrow", 32'(borrow_out), 32'd0);

        // Start together with reset must not launch anything.
        start = 1'b1;
        a_in  = 8'd7;
        b_in  = 8'd1;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_op(8'd100, 8'd37, 8'd63, 1'b0, "t1_100m37");
        run_op(8'd5, 8'd10, 8'hFB, 1'b1, "t2_5m10");
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, "t3_0m1");
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, "t3_FFmFF");

        // Start held high with new operands throughout SHIFT is ignored.
        @(negedge clk);
        a_in  = 8'd200;
        b_in  = 8'd50;
        start = 1'b1;
        @(negedge clk);
        a_in = 8'd1;
        b_in = 8'd2;
        for (int i = 0; i < W; i++) begin
            check("t4_no_done_in_shift", 32'(done), 32'd0);
            @(negedge clk);
        end
        check("t4_done", 32'(done), 32'd1);
        check("t4_diff", 32'(diff_out), 32'd150);
        check("t4_borrow", 32'(borrow_out), 32'd0);
        start = 1'b0;
        @(negedge clk);
        check("t4_single_done", 32'(done), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        prev_d = 8'd150;
        prev_b = 1'b0;
        run_op(8'd1, 8'd2, 8'hFF, 1'b1, "t4_1m2");

        // Reset on the 4th SHIFT edge aborts the operation.
        @(negedge clk);
        a_in  = 8'd9;
        b_in  = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_diff", 32'(diff_out), 32'd0);
        check("t5_borrow", 32'(borrow_out), 32'd0);
        for (int i = 0; i < W; i++) begin
            check("t5_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        prev_d = '0;
        prev_b = 1'b0;
        run_op(8'd9, 8'd3, 8'd6, 1'b0, "t5_9m3");

        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_op(ra, rb, W'(ra - rb), (ra < rb), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
